// File: rtl/mult_seq_controller.sv
// Sequencer for an iterative LUT-based shift-accumulate multiplier datapath:
// clear/operand load, one-hot LUT loads, then ITERS shift/add rounds with a start/done handshake.
module mult_seq_controller #(
  parameter int NUM_LUT = 2,
  parameter int ITERS   = 4,
  localparam int CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               done_ack,
  input  logic               abort,
  output logic               rst_out,
  output logic               ld_A,
  output logic               ld_B,
  output logic [NUM_LUT-1:0] lut_ld,
  output logic [1:0]         shctrl,
  output logic               ld_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   iter
);

  localparam int LUT_W = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;
  localparam logic [LUT_W-1:0] LUT_LAST  = LUT_W'(NUM_LUT - 1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LUT   = 3'd2,
    S_SHIFT = 3'd3,
    S_ACC   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [LUT_W-1:0]   lut_idx, lut_nx;
  logic [CNT_W-1:0]   iter_nx;
  logic [NUM_LUT-1:0] lut_onehot;

  always_comb begin
    state_nx = state;
    lut_nx   = lut_idx;
    iter_nx  = iter;
    if (abort) begin
      state_nx = S_IDLE;
      if (state != S_IDLE) begin
        lut_nx  = '0;
        iter_nx = '0;
      end
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_LOAD;
        S_LOAD: begin
          lut_nx   = '0;
          iter_nx  = '0;
          state_nx = S_LUT;
        end
        S_LUT: begin
          if (lut_idx == LUT_LAST) state_nx = S_SHIFT;
          else                     lut_nx   = lut_idx + LUT_W'(1);
        end
        S_SHIFT: state_nx = S_ACC;
        S_ACC: begin
          if (iter == ITER_LAST) begin
            state_nx = S_DONE;
          end else begin
            iter_nx  = iter + CNT_W'(1);
            state_nx = S_SHIFT;
          end
        end
        S_DONE:  if (done_ack) state_nx = start ? S_LOAD : S_IDLE;
        default: begin
          state_nx = S_IDLE;
          lut_nx   = '0;
          iter_nx  = '0;
        end
      endcase
    end
  end

  always_comb begin
    lut_onehot = '0;
    for (int unsigned i = 0; i < NUM_LUT; i++)
      lut_onehot[i] = (lut_nx == LUT_W'(i));
  end

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      lut_idx <= '0;
      iter    <= '0;
      rst_out <= 1'b0;
      ld_A    <= 1'b0;
      ld_B    <= 1'b0;
      lut_ld  <= '0;
      shctrl  <= 2'b00;
      ld_out  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      lut_idx <= lut_nx;
      iter    <= iter_nx;
      rst_out <= (state_nx == S_LOAD);
      ld_A    <= (state_nx == S_LOAD);
      ld_B    <= (state_nx == S_LOAD);
      lut_ld  <= (state_nx == S_LUT) ? lut_onehot : '0;
      shctrl  <= (state_nx == S_SHIFT) ? 2'b01 :
                 (state_nx == S_ACC)   ? 2'b10 : 2'b00;
      ld_out  <= (state_nx == S_ACC);
      busy    <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done    <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_mult_seq_controller.sv
// Directed bench for mult_seq_controller: default instance (NUM_LUT=2, ITERS=4)
// plus a NUM_LUT=3, ITERS=1 instance driven from the same inputs.
module tb_mult_seq_controller;

  logic clk, rst, start, done_ack, abort;

  logic       rst_out, ld_A, ld_B, ld_out, busy, done;
  logic [1:0] lut_ld, shctrl, iter;

  logic       rst_out2, ld_A2, ld_B2, ld_out2, busy2, done2;
  logic [2:0] lut_ld2;
  logic [1:0] shctrl2;
  logic [0:0] iter2;

  logic [9:0]  v1;
  logic [10:0] v2;
  assign v1 = {rst_out, ld_A, ld_B, lut_ld, shctrl, ld_out, busy, done};
  assign v2 = {rst_out2, ld_A2, ld_B2, lut_ld2, shctrl2, ld_out2, busy2, done2};

  // {rst_out,ld_A,ld_B,lut_ld[1:0],shctrl,ld_out,busy,done}
  localparam logic [9:0] V_IDLE = 10'b000_00_00_000;
  localparam logic [9:0] V_LOAD = 10'b111_00_00_010;
  localparam logic [9:0] V_LUT0 = 10'b000_01_00_010;
  localparam logic [9:0] V_LUT1 = 10'b000_10_00_010;
  localparam logic [9:0] V_SH   = 10'b000_00_01_010;
  localparam logic [9:0] V_ACC  = 10'b000_00_10_110;
  localparam logic [9:0] V_DONE = 10'b000_00_00_001;

  int n_assert = 0;
  int n_fail   = 0;

  mult_seq_controller #(.NUM_LUT(2), .ITERS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .done_ack(done_ack), .abort(abort),
    .rst_out(rst_out), .ld_A(ld_A), .ld_B(ld_B), .lut_ld(lut_ld), .shctrl(shctrl),
    .ld_out(ld_out), .busy(busy), .done(done), .iter(iter)
  );

  mult_seq_controller #(.NUM_LUT(3), .ITERS(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .done_ack(done_ack), .abort(abort),
    .rst_out(rst_out2), .ld_A(ld_A2), .ld_B(ld_B2), .lut_ld(lut_ld2), .shctrl(shctrl2),
    .ld_out(ld_out2), .busy(busy2), .done(done2), .iter(iter2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] exp1(input int c);
    case (c)
      1:       return V_LOAD;
      2:       return V_LUT0;
      3:       return V_LUT1;
      12:      return V_DONE;
      default: return (c % 2 == 0) ? V_SH : V_ACC;
    endcase
  endfunction

  function automatic logic [1:0] exp_iter1(input int c);
    if (c <= 4)  return 2'd0;
    if (c >= 11) return 2'd3;
    return 2'((c - 4) / 2);
  endfunction

  function automatic logic [10:0] exp2(input int c);
    case (c)
      1:       return 11'b111_000_00_010;
      2:       return 11'b000_001_00_010;
      3:       return 11'b000_010_00_010;
      4:       return 11'b000_100_00_010;
      5:       return 11'b000_000_01_010;
      6:       return 11'b000_000_10_110;
      default: return 11'b000_000_00_001;
    endcase
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; done_ack = 1'b0; abort = 1'b0;
    #1;
    chk("reset_vec", 32'(v1), 32'(V_IDLE));
    chk("reset_iter", 32'(iter), 32'd0);
    chk("reset_vec2", 32'(v2), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("idle_vec", 32'(v1), 32'(V_IDLE));

    // Full operation on both instances
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("op1_vec_c%0d", c), 32'(v1), 32'(exp1(c)));
      chk($sformatf("op1_iter_c%0d", c), 32'(iter), 32'(exp_iter1(c)));
      chk($sformatf("op2_vec_c%0d", c), 32'(v2), 32'(exp2(c)));
      chk($sformatf("op2_iter_c%0d", c), 32'(iter2), 32'd0);
    end

    // Hold done without ack; start alone must not restart
    for (int c = 13; c <= 17; c++) begin
      start = (c == 14 || c == 15);
      tick();
      chk($sformatf("hold_vec_c%0d", c), 32'(v1), 32'(V_DONE));
      chk($sformatf("hold_iter_c%0d", c), 32'(iter), 32'd3);
    end
    start = 1'b0;
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("ack_idle_vec", 32'(v1), 32'(V_IDLE));
    chk("ack_idle_vec2", 32'(v2), 32'd0);

    // Back-to-back restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) tick();
    chk("b2b_first_done", 32'(v1), 32'(V_DONE));
    done_ack = 1'b1; start = 1'b1;
    tick();
    done_ack = 1'b0; start = 1'b0;
    chk("b2b_load", 32'(v1), 32'(V_LOAD));
    for (int c = 2; c <= 11; c++) tick();
    chk("b2b_not_yet_done", 32'(done), 32'd0);
    tick();
    chk("b2b_second_done", 32'(v1), 32'(V_DONE));
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("b2b_idle", 32'(v1), 32'(V_IDLE));

    // Start during SHIFT ignored, then abort
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_shift_vec", 32'(v1), 32'(V_SH));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy_acc", 32'(v1), 32'(V_ACC));
    tick(); tick();
    chk("abort_pre_vec", 32'(v1), 32'(V_ACC));
    chk("abort_pre_done2", 32'(v2), 32'(V_DONE) | 32'd0 | 32'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_vec", 32'(v1), 32'(V_IDLE));
    chk("abort_idle_iter", 32'(iter), 32'd0);
    chk("abort_idle_vec2", 32'(v2), 32'd0);
    tick(); tick();
    chk("abort_no_pending", 32'(v1), 32'(V_IDLE));

    // Asynchronous reset in the middle of LUT loading
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("arst_pre_lut", 32'(v1), 32'(V_LUT0));
    #2 rst = 1'b0;
    #1;
    chk("arst_vec", 32'(v1), 32'(V_IDLE));
    chk("arst_iter", 32'(iter), 32'd0);
    chk("arst_vec2", 32'(v2), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst_restart_load", 32'(v1), 32'(V_LOAD));
    tick();
    chk("arst_restart_lut0", 32'(v1), 32'(V_LUT0));
    for (int c = 3; c <= 11; c++) tick();
    chk("arst_restart_c11", 32'(v1), 32'(V_ACC));
    tick();
    chk("arst_restart_done", 32'(v1), 32'(V_DONE));

    // Abort outranks ack+start in DONE
    abort = 1'b1; done_ack = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; done_ack = 1'b0; start = 1'b0;
    chk("abort_prio_vec", 32'(v1), 32'(V_IDLE));
    chk("abort_prio_iter", 32'(iter), 32'd0);
    tick();
    chk("abort_prio_stay", 32'(v1), 32'(V_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
- Parametrised successor to the phase-2 multiplier controller. It sequences an iterative LUT-based shift-accumulate multiplier datapath: clear and operand load, per-LUT load strobes, then ITERS shift/accumulate rounds.
- Adds a start/done handshake with acknowledge, back-to-back restart, synchronous abort, and busy/iteration status.
- Sits between the top-level core and the operand registers, LUT bank, shifter and output register.

Parameters:
- NUM_LUT, 2, number of LUTs loaded in sequence; must be >= 1.
- ITERS, 4, number of shift/accumulate rounds per operation; must be >= 1.
- CNT_W, max(1,$clog2(ITERS)), derived localparam: width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled in IDLE, and in DONE together with done_ack.
- done_ack  input  1  consumer acknowledges the result; releases DONE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- rst_out  output  1  clear datapath accumulator/output.
- ld_A  output  1  load operand A.
- ld_B  output  1  load operand B.
- lut_ld  output  NUM_LUT  one-hot LUT load strobe.
- shctrl  output  2  shifter control: 00 hold, 01 shift, 10 add-and-shift, 11 unused (never driven).
- ld_out  output  1  load output register.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  result valid; held until acknowledged.
- iter  output  CNT_W  current round index, 0..ITERS-1.

Behaviour:
- Moore FSM with states IDLE, LOAD, LUT, SHIFT, ACC, DONE. A lut_idx counter (width max(1,clog2(NUM_LUT))) and an iter counter are registered.
- All outputs are decoded from the registered state only. There is no combinational path from any input to any output.
- Reset (rst=0, asynchronous): state=IDLE, lut_idx=0, iter=0. All outputs are 0: lut_ld=0, shctrl=00, busy=0, done=0.
- Reset asserted mid-operation aborts immediately. No done is produced.
- IDLE: all strobes 0. If start=1, go to LOAD; otherwise stay.
- LOAD (1 cycle): rst_out=1, ld_A=1, ld_B=1. Clear lut_idx and iter, then go to LUT.
- LUT (NUM_LUT cycles): lut_ld bit[lut_idx]=1 and all other bits 0. lut_idx increments each cycle. After lut_idx==NUM_LUT-1, go to SHIFT.
- SHIFT (1 cycle): shctrl=01. Go to ACC.
- ACC (1 cycle): shctrl=10, ld_out=1.
  - If iter==ITERS-1, go to DONE and leave iter unchanged.
  - Otherwise increment iter and go to SHIFT.
- DONE: done=1, iter holds the last value, all strobes 0.
  - done_ack=1 with start=0: go to IDLE.
  - done_ack=1 with start=1: go directly to LOAD (back-to-back, no IDLE cycle).
  - done_ack=0: stay in DONE. A start without done_ack is ignored.
- start is ignored while busy=1. A pending start is not queued.
- abort=1 in any state: next state=IDLE, counters cleared. abort takes priority over start and done_ack. abort in IDLE has no effect.
- Latency: start sampled at edge 0 puts the FSM in LOAD at edge 1. done first rises at edge 2+NUM_LUT+2*ITERS. With defaults this is edge 12.
- Strobe totals per operation: exactly one ld_A pulse and one ld_B pulse; exactly one pulse on each lut_ld bit; ITERS shctrl=01 cycles; ITERS ld_out pulses.
- Illegal or unused state encodings recover to IDLE on the next clock.

Test Plan:
- Reset then start pulse (defaults) -> LOAD at cycle 1; lut_ld=01 then 10 at cycles 2-3; shctrl 01/10 alternating for cycles 4-11 with ld_out at 5,7,9,11; done=1 at cycle 12, iter=3.
- Hold done_ack=0 for 5 cycles after done -> done stays 1 and all strobes 0. Then done_ack=1 -> IDLE next cycle, done=0.
- done_ack=1 and start=1 in the same DONE cycle -> LOAD on the next cycle; second done exactly 12 cycles after that ack.
- start pulsed during SHIFT, then abort=1 at cycle 7 -> start ignored; IDLE at cycle 8, busy=0, no done, iter=0.
- rst=0 asserted asynchronously mid-LUT -> outputs 0 immediately without waiting for a clock edge; after release, a start gives normal timing.
- Parameter sweep NUM_LUT=3, ITERS=1 -> lut_ld 001/010/100, one SHIFT/ACC pair, done at edge 7; CNT_W=1, iter=0.
